instr_mem_loadable: RTL and testbench

Parametrised, synchronous instruction memory for the processor fetch stage, replacing the fixed 32-word combinational ROM. It gives a registered fetch port with request/valid, plus alignment and range error flags. A byte-serial program-load port fills the memory at run time: an FSM first clears the array, then packs incoming bytes into words. Fetches are refused while a load is in progress, so the core never executes a half-written program.

---
 rtl/instr_mem_pkg.sv | 9 +
 rtl/instr_word_packer.sv | 36 +++
 rtl/instr_mem_loadable.sv | 112 +++++++++++
 tb/tb_instr_mem_loadable.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: FSM states, default word geometry and fetch word-index helper for instr_mem_loadable
package instr_mem_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction
endpackage

// File: rtl/instr_word_packer.sv
// instr_word_packer: packs accepted bytes into words (byte_valid_i/byte_i/last_i in, word_valid_o/word_data_o out, zero-padded flush on last)
module instr_word_packer #(
  parameter int DATA_W = 32,
  parameter int BPW = DATA_W / 8,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              last_i,
  output logic              word_valid_o,
  output logic [DATA_W-1:0] word_data_o
);
  localparam int CW = $clog2(BPW + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, merged;
  always_comb begin
    merged = BIG_ENDIAN ? ((acc_q << 8) | DATA_W'(byte_i))
                        : (acc_q | (DATA_W'(byte_i) << (8 * int'(cnt_q))));
    word_valid_o = byte_valid_i && (last_i || cnt_q == CW'(BPW - 1));
    word_data_o = BIG_ENDIAN ? merged << (8 * (BPW - 1 - int'(cnt_q))) : merged;
    cnt_d = (clear_i || word_valid_o) ? '0 : byte_valid_i ? cnt_q + 1'b1 : cnt_q;
    acc_d = (clear_i || word_valid_o) ? '0 : byte_valid_i ? merged : acc_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable instruction memory; registered fetch port (fetch_req_i/addr_i -> instr_o/instr_valid_o/misalign_o/oob_o) and byte-serial load port (load_* with clear-then-pack FSM)
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 32,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fetch_req_i,
  input  logic [ADDR_W-1:0]          addr_i,
  output logic [DATA_W-1:0]          instr_o,
  output logic                       instr_valid_o,
  output logic                       misalign_o,
  output logic                       oob_o,
  output logic                       fetch_busy_o,
  input  logic                       load_start_i,
  input  logic                       load_byte_valid_i,
  input  logic [7:0]                 load_byte_i,
  input  logic                       load_last_i,
  output logic                       load_ready_o,
  output logic                       load_done_o,
  output logic [$clog2(DEPTH+1)-1:0] load_count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d, word_data, rdata;
  logic valid_q, valid_d, mis_q, mis_d, oob_q, oob_d;
  logic busy, byte_acc, word_valid, fetch_acc, fetch_oob;
  logic [31:0] widx;
  assign busy = state_q == CLEAR || state_q == LOAD;
  assign fetch_busy_o = busy;
  assign load_ready_o = state_q == LOAD;
  assign load_done_o = state_q == DONE;
  assign load_count_o = count_q;
  assign instr_o = instr_q;
  assign instr_valid_o = valid_q;
  assign misalign_o = mis_q;
  assign oob_o = oob_q;
  instr_word_packer #(
    .DATA_W(DATA_W),
    .BPW(DATA_W / 8),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clear_i(state_q == IDLE),
    .byte_valid_i(byte_acc),
    .byte_i(load_byte_i),
    .last_i(load_last_i),
    .word_valid_o(word_valid),
    .word_data_o(word_data)
  );
  always_comb begin
    widx = word_index(32'(addr_i));
    fetch_oob = widx >= 32'(DEPTH);
    rdata = fetch_oob ? '0 : mem[widx[AW-1:0]];
    fetch_acc = fetch_req_i && !busy;
    instr_d = fetch_acc ? rdata : instr_q;
    valid_d = fetch_acc;
    mis_d = fetch_acc && addr_i[1:0] != 2'b00;
    oob_d = fetch_acc && fetch_oob;
    byte_acc = load_byte_valid_i && state_q == LOAD;
    state_d = state_q;
    count_d = count_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        state_d = load_start_i ? CLEAR : IDLE;
        count_d = load_start_i ? '0 : count_q;
        clr_idx_d = '0;
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        state_d = clr_idx_q == CW'(DEPTH - 1) ? LOAD : CLEAR;
      end
      LOAD: begin
        count_d = count_q + CW'(word_valid);
        state_d = ((byte_acc && load_last_i) || (word_valid && count_q == CW'(DEPTH - 1))) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) mem[clr_idx_q[AW-1:0]] <= '0;
    else if (word_valid) mem[count_q[AW-1:0]] <= word_data;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      clr_idx_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clr_idx_q <= clr_idx_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q <= mis_d;
      oob_q <= oob_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: big- and little-endian instances driven in parallel against a cycle-level byte/word reference model
module tb_instr_mem_loadable;
  localparam int DEPTH = 32;
  localparam int IW = $clog2(DEPTH);
  logic clk = 0, rst = 1, fetch_req = 0, load_start = 0, bv = 0, last = 0;
  logic [7:0] lb = 0;
  logic [31:0] addr = 0;
  logic [31:0] instr_b, instr_l;
  logic vb, vl, misb, misl, oobb, oobl, busyb, busyl, readyb, readyl, doneb, donel;
  logic [5:0] cntb, cntl;
  int total = 0, passed = 0;
  logic [31:0] mem_be [DEPTH];
  logic [31:0] mem_le [DEPTH];
  int m_state = 0, clr_left = 0, m_count = 0, pn = 0;
  logic [31:0] p_be = 0, p_le = 0, held_be = 0, held_le = 0;
  logic [7:0] prog [$];

  always #5 clk = ~clk;

  instr_mem_loadable #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1)) dut_be (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(fetch_req), .addr_i(addr),
    .instr_o(instr_b), .instr_valid_o(vb), .misalign_o(misb), .oob_o(oobb),
    .fetch_busy_o(busyb), .load_start_i(load_start), .load_byte_valid_i(bv),
    .load_byte_i(lb), .load_last_i(last), .load_ready_o(readyb),
    .load_done_o(doneb), .load_count_o(cntb));

  instr_mem_loadable #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(0)) dut_le (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(fetch_req), .addr_i(addr),
    .instr_o(instr_l), .instr_valid_o(vl), .misalign_o(misl), .oob_o(oobl),
    .fetch_busy_o(busyl), .load_start_i(load_start), .load_byte_valid_i(bv),
    .load_byte_i(lb), .load_last_i(last), .load_ready_o(readyl),
    .load_done_o(donel), .load_count_o(cntl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    logic req, e_mis, e_oob;
    logic [31:0] w, e_be, e_le;
    req = fetch_req && !(m_state == 1 || m_state == 2);
    w = addr >> 2;
    e_oob = w >= DEPTH;
    e_mis = addr[1:0] != 2'b00;
    e_be = 0;
    e_le = 0;
    if (!e_oob) begin
      e_be = mem_be[w[IW-1:0]];
      e_le = mem_le[w[IW-1:0]];
    end
    case (m_state)
      0: if (load_start) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_be[i] = 0;
          mem_le[i] = 0;
        end
        m_count = 0;
        pn = 0;
        clr_left = DEPTH;
        m_state = 1;
      end
      1: begin
        clr_left--;
        if (clr_left == 0) m_state = 2;
      end
      2: if (bv) begin
        p_be |= 32'(lb) << (24 - 8 * pn);
        p_le |= 32'(lb) << (8 * pn);
        pn++;
        if (pn == 4 || last) begin
          mem_be[m_count] = p_be;
          mem_le[m_count] = p_le;
          m_count++;
          pn = 0;
          p_be = 0;
          p_le = 0;
        end
        if (last || m_count == DEPTH) m_state = 3;
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    if (req) begin
      held_be = e_be;
      held_le = e_le;
    end
    chk("valid", 32'(vb), 32'(req));
    chk("valid_le", 32'(vl), 32'(req));
    chk("misalign", 32'(misb), 32'(req && e_mis));
    chk("oob", 32'(oobb), 32'(req && e_oob));
    chk("instr_be", instr_b, held_be);
    chk("instr_le", instr_l, held_le);
    chk("busy", 32'(busyb), 32'(m_state == 1 || m_state == 2));
    chk("ready", 32'(readyb), 32'(m_state == 2));
    chk("done", 32'(doneb), 32'(m_state == 3));
    chk("done_le", 32'(donel), 32'(m_state == 3));
    chk("count", 32'(cntb), 32'(m_count));
    chk("count_le", 32'(cntl), 32'(m_count));
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_valid", 32'(vb), 0);
    chk("rst_instr", instr_b, 0);
    chk("rst_count", 32'(cntb), 0);
    chk("rst_ready", 32'(readyb), 0);
    chk("rst_busy", 32'(busyb), 0);
    chk("rst_done", 32'(doneb), 0);
    chk("rst_mis", 32'(misb), 0);
    chk("rst_oob", 32'(oobb), 0);
    m_state = 0;
    m_count = 0;
    pn = 0;
    p_be = 0;
    p_le = 0;
    held_be = 0;
    held_le = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic run_load(input int n, input bit with_last, input int stop_at);
    load_start = 1;
    step();
    load_start = 0;
    while (m_state == 1) step();
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) begin
        bv = 0;
        last = 0;
        return;
      end
      bv = 1;
      lb = prog[i];
      last = with_last && i == n - 1;
      step();
    end
    bv = 0;
    last = 0;
    step();
    step();
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1;
    addr = a;
    step();
    fetch_req = 0;
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #1;
    do_reset();
    step();
    bv = 1;
    lb = 8'h55;
    step();
    bv = 0;
    prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(8, 1, -1);
    fetch(32'h0);
    chk("be_w0", instr_b, 32'h12345678);
    chk("le_w0_a", instr_l, 32'h78563412);
    fetch(32'h4);
    chk("be_w1", instr_b, 32'h9ABCDEF0);
    chk("count2", 32'(cntb), 2);
    fetch(32'h82);
    chk("oob_flag", 32'(oobb), 1);
    chk("oob_instr", instr_b, 0);
    fetch(32'h6);
    chk("mis_flag", 32'(misb), 1);
    chk("mis_instr", instr_b, 32'h9ABCDEF0);
    fetch_req = 1;
    for (int i = 0; i < 12; i++) begin
      addr = $urandom_range(0, 4 * DEPTH + 15);
      step();
    end
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    addr = 32'h4;
    run_load(5, 1, -1);
    fetch_req = 0;
    fetch(32'h0);
    chk("le_w0", instr_l, 32'hDDCCBBAA);
    fetch(32'h4);
    chk("le_w1", instr_l, 32'h000000EE);
    for (int i = 2; i < DEPTH; i++) fetch(32'(4 * i));
    rand_prog(16);
    run_load(16, 0, 11);
    do_reset();
    chk("rst_mid_ready", 32'(readyb), 0);
    step();
    fetch(32'h8);
    chk("rst_mid_w2", instr_b, 0);
    fetch(32'h0);
    fetch(32'h4);
    rand_prog(4 * DEPTH + 4);
    run_load(4 * DEPTH + 4, 0, -1);
    chk("full_count", 32'(cntb), DEPTH);
    chk("full_ready", 32'(readyb), 0);
    for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i + $urandom_range(0, 3)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
